// File: rtl/ibex_ipm_arbiter.sv
// Two-port arbiter and sequencer for the shared IPM multiplier.
// Port 0 is the core pipeline, port 1 a secondary requester.
module ibex_ipm_arbiter #(
   parameter int unsigned TimeoutCycles = 64,
   parameter int unsigned OpWidth       = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [1:0]         req_i,
   input  logic [OpWidth-1:0] op0_i,
   input  logic [OpWidth-1:0] op1_i,
   input  logic [31:0]        a0_i,
   input  logic [31:0]        b0_i,
   input  logic [31:0]        a1_i,
   input  logic [31:0]        b1_i,
   output logic [1:0]         gnt_o,
   output logic [1:0]         rvalid_o,
   input  logic [1:0]         rready_i,
   output logic [31:0]        rdata_o,
   output logic               err_o,
   input  logic               flush0_i,
   output logic               busy_o,
   output logic               ipm_en_o,
   output logic               ipm_sel_o,
   output logic [OpWidth-1:0] ipm_operator_o,
   output logic [31:0]        ipm_operand_a_o,
   output logic [31:0]        ipm_operand_b_o,
   input  logic [31:0]        ipm_result_i,
   input  logic               ipm_valid_i
);

   localparam int unsigned CntW = $clog2(TimeoutCycles);
   localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      BUSY,
      RESP,
      DRAIN
   } state_e;

   state_e               state_q;
   logic [CntW-1:0]      cnt_q;
   logic                 owner_q;
   logic                 last_q;
   logic                 err_q;
   logic [31:0]          rdata_q;
   logic [OpWidth-1:0]   op_q;
   logic [31:0]          a_q;
   logic [31:0]          b_q;

   logic [1:0] req_eff;
   logic       pick;
   logic       timeout;
   logic       kill;

   // a flushing core cannot win arbitration for port 0
   assign req_eff = {req_i[1], req_i[0] & ~flush0_i};
   assign timeout = (cnt_q == CntMax);
   assign kill    = flush0_i & ~owner_q;

   always_comb begin
      pick = 1'b0;
      if (req_eff == 2'b11) begin
         pick = ~last_q;
      end else begin
         pick = req_eff[1];
      end
   end

   assign gnt_o = (state_q == IDLE && |req_eff) ?
                  (pick ? 2'b10 : 2'b01) : 2'b00;

   assign rvalid_o = (state_q != RESP) ? 2'b00 :
                     (owner_q ? 2'b10 : 2'b01);

   assign busy_o          = (state_q != IDLE);
   assign ipm_en_o        = (state_q == START);
   assign ipm_sel_o       = (state_q == START) ||
                            (state_q == BUSY)  ||
                            (state_q == DRAIN);
   assign err_o           = err_q;
   assign rdata_o         = rdata_q;
   assign ipm_operator_o  = op_q;
   assign ipm_operand_a_o = a_q;
   assign ipm_operand_b_o = b_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         err_q   <= 1'b0;
         rdata_q <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (|req_eff) begin
                  owner_q <= pick;
                  last_q  <= pick;
                  op_q    <= pick ? op1_i : op0_i;
                  a_q     <= pick ? a1_i : a0_i;
                  b_q     <= pick ? b1_i : b0_i;
                  state_q <= START;
               end
            end
            START: begin
               cnt_q   <= '0;
               state_q <= kill ? DRAIN : BUSY;
            end
            BUSY: begin
               cnt_q <= cnt_q + 1'b1;
               if (kill) begin
                  state_q <= (ipm_valid_i || timeout) ? IDLE : DRAIN;
               end else if (ipm_valid_i) begin
                  rdata_q <= ipm_result_i;
                  err_q   <= 1'b0;
                  state_q <= RESP;
               end else if (timeout) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  state_q <= RESP;
               end
            end
            DRAIN: begin
               cnt_q <= cnt_q + 1'b1;
               if (ipm_valid_i || timeout) begin
                  state_q <= IDLE;
               end
            end
            RESP: begin
               if (kill || rready_i[owner_q]) begin
                  err_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ibex_ipm_arbiter.sv
// Directed bench for ibex_ipm_arbiter with an 8-cycle timeout.
module tb_ibex_ipm_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic [1:0]  op0;
   logic [1:0]  op1;
   logic [31:0] a0;
   logic [31:0] b0;
   logic [31:0] a1;
   logic [31:0] b1;
   logic [1:0]  gnt;
   logic [1:0]  rvalid;
   logic [1:0]  rready;
   logic [31:0] rdata;
   logic        err;
   logic        flush0;
   logic        busy;
   logic        en;
   logic        sel;
   logic [1:0]  opr;
   logic [31:0] opa;
   logic [31:0] opb;
   logic [31:0] res;
   logic        vld;

   int n_assert = 0;
   int n_fail   = 0;

   ibex_ipm_arbiter #(
      .TimeoutCycles(8),
      .OpWidth(2)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .req_i(req),
      .op0_i(op0),
      .op1_i(op1),
      .a0_i(a0),
      .b0_i(b0),
      .a1_i(a1),
      .b1_i(b1),
      .gnt_o(gnt),
      .rvalid_o(rvalid),
      .rready_i(rready),
      .rdata_o(rdata),
      .err_o(err),
      .flush0_i(flush0),
      .busy_o(busy),
      .ipm_en_o(en),
      .ipm_sel_o(sel),
      .ipm_operator_o(opr),
      .ipm_operand_a_o(opa),
      .ipm_operand_b_o(opb),
      .ipm_result_i(res),
      .ipm_valid_i(vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      req    = 2'b00;
      op0    = 2'd1;
      op1    = 2'd2;
      a0     = 32'h3;
      b0     = 32'h5;
      a1     = 32'h77;
      b1     = 32'h99;
      rready = 2'b00;
      flush0 = 1'b0;
      res    = 32'h0;
      vld    = 1'b0;
      #12;
      chk("rst_gnt", {30'd0, gnt}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rvalid", {30'd0, rvalid}, 32'd0);
      chk("rst_en_sel", {30'd0, en, sel}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_opa", opa, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // single port-0 operation, latency T0..T3
      req = 2'b01;
      settle();
      chk("t1_gnt_T0", {30'd0, gnt}, 32'h1);
      tick();
      req = 2'b00;
      settle();
      chk("t1_en_T1", {31'd0, en}, 32'h1);
      chk("t1_opa", opa, 32'h3);
      chk("t1_opb", opb, 32'h5);
      chk("t1_op", {30'd0, opr}, 32'h1);
      tick();
      vld = 1'b1;
      res = 32'hF;
      settle();
      chk("t1_en_T2", {31'd0, en}, 32'h0);
      chk("t1_rvalid_T2", {30'd0, rvalid}, 32'h0);
      tick();
      vld = 1'b0;
      settle();
      chk("t1_rvalid_T3", {30'd0, rvalid}, 32'h1);
      chk("t1_rdata", rdata, 32'hF);
      chk("t1_err", {31'd0, err}, 32'h0);
      rready = 2'b01;
      tick();
      rready = 2'b00;
      settle();
      chk("t1_busy_after", {31'd0, busy}, 32'h0);
      chk("t1_rvalid_after", {30'd0, rvalid}, 32'h0);

      // contention from a fresh reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      req = 2'b11;
      settle();
      chk("c_gnt_first", {30'd0, gnt}, 32'h1);
      tick();
      req = 2'b10;
      settle();
      chk("c_gnt_start", {30'd0, gnt}, 32'h0);
      tick();
      vld = 1'b1;
      res = 32'h11;
      tick();
      vld = 1'b0;
      settle();
      chk("c_rvalid0", {30'd0, rvalid}, 32'h1);
      chk("c_rdata0", rdata, 32'h11);
      chk("c_gnt_resp", {30'd0, gnt}, 32'h0);
      rready = 2'b01;
      tick();
      rready = 2'b00;
      settle();
      chk("c_gnt_second", {30'd0, gnt}, 32'h2);
      tick();
      req = 2'b00;
      settle();
      chk("c_opa1", opa, 32'h77);
      chk("c_op1", {30'd0, opr}, 32'h2);
      tick();
      vld = 1'b1;
      res = 32'h22;
      tick();
      vld = 1'b0;
      settle();
      chk("c_rvalid1", {30'd0, rvalid}, 32'h2);
      chk("c_rdata1", rdata, 32'h22);
      rready = 2'b10;
      tick();
      rready = 2'b00;
      req = 2'b11;
      settle();
      chk("c_gnt_third", {30'd0, gnt}, 32'h1);

      // finish port 0, then port 1 runs with backpressure
      tick();
      req = 2'b10;
      tick();
      vld = 1'b1;
      res = 32'h33;
      tick();
      vld = 1'b0;
      rready = 2'b01;
      tick();
      rready = 2'b00;
      settle();
      chk("bp_gnt1", {30'd0, gnt}, 32'h2);
      tick();
      req = 2'b01;
      tick();
      vld = 1'b1;
      res = 32'hABCD1234;
      tick();
      vld = 1'b0;
      for (int i = 0; i < 10; i++) begin
         settle();
         chk("bp_rvalid", {30'd0, rvalid}, 32'h2);
         chk("bp_rdata", rdata, 32'hABCD1234);
         chk("bp_gnt", {30'd0, gnt}, 32'h0);
         tick();
      end
      rready = 2'b10;
      tick();
      rready = 2'b00;
      settle();
      chk("bp_gnt0_after", {30'd0, gnt}, 32'h1);

      // timeout: IPM never answers
      tick();
      req = 2'b00;
      tick();
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("to_wait", {30'd0, rvalid}, 32'h0);
      end
      tick();
      chk("to_rvalid", {30'd0, rvalid}, 32'h1);
      chk("to_err", {31'd0, err}, 32'h1);
      chk("to_rdata", rdata, 32'h0);
      rready = 2'b01;
      tick();
      rready = 2'b00;
      settle();
      chk("to_err_clr", {31'd0, err}, 32'h0);

      // flush while port 0 is busy, port 1 waiting
      req = 2'b01;
      settle();
      chk("fl_gnt0", {30'd0, gnt}, 32'h1);
      tick();
      req = 2'b10;
      tick();
      flush0 = 1'b1;
      tick();
      flush0 = 1'b0;
      settle();
      chk("fl_sel_d1", {31'd0, sel}, 32'h1);
      chk("fl_rvalid_d1", {30'd0, rvalid}, 32'h0);
      tick();
      chk("fl_sel_d2", {31'd0, sel}, 32'h1);
      tick();
      vld = 1'b1;
      res = 32'h44;
      settle();
      chk("fl_sel_d3", {31'd0, sel}, 32'h1);
      chk("fl_gnt_drain", {30'd0, gnt}, 32'h0);
      tick();
      vld = 1'b0;
      settle();
      chk("fl_rvalid_exit", {30'd0, rvalid}, 32'h0);
      chk("fl_err_exit", {31'd0, err}, 32'h0);
      chk("fl_sel_exit", {31'd0, sel}, 32'h0);
      chk("fl_gnt1", {30'd0, gnt}, 32'h2);

      // reset while port 1 is busy
      tick();
      req = 2'b00;
      tick();
      chk("rb_busy_pre", {31'd0, busy}, 32'h1);
      rst_n = 1'b0;
      settle();
      chk("rb_busy", {31'd0, busy}, 32'h0);
      chk("rb_sel", {31'd0, sel}, 32'h0);
      chk("rb_opa", opa, 32'h0);
      tick();
      rst_n = 1'b1;
      vld = 1'b1;
      res = 32'h55;
      tick();
      vld = 1'b0;
      settle();
      chk("rb_rvalid", {30'd0, rvalid}, 32'h0);
      chk("rb_busy_post", {31'd0, busy}, 32'h0);

      // a flushing core request is not granted
      req = 2'b01;
      flush0 = 1'b1;
      settle();
      chk("fm_gnt", {30'd0, gnt}, 32'h0);
      flush0 = 1'b0;
      req = 2'b00;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
